// File: rtl/accum_warp_addr_drain_pkg.sv
// Shared sizing for the warp address drain: lane count, address width, config count.
// Also holds the id typedef and the drain FSM state encoding.
package accum_warp_addr_drain_pkg;
    localparam int VSIZE          = 4;
    localparam int GLOBAL_ADDR_BW = 16;
    localparam int N_ICFG         = 4;
    localparam int NCFG_BW        = $clog2(N_ICFG + 1);

    typedef logic [NCFG_BW-1:0] cfg_id_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;
endpackage

// File: rtl/warp_lane_coalescer.sv
// Picks the lowest pending lane as leader and flags every pending lane sharing its address.
// Purely combinational; no latency, no backpressure.
module warp_lane_coalescer #(
    parameter int VSIZE = 4,
    parameter int ABW   = 16
) (
    input  logic [VSIZE-1:0][ABW-1:0] address,
    input  logic [VSIZE-1:0]          pending,
    output logic [ABW-1:0]            lead_address,
    output logic [VSIZE-1:0]          match
);
    localparam int IW = $clog2(VSIZE);

    logic [IW-1:0] lead_idx;

    // Scanning downward leaves the lowest set bit as the final winner.
    always_comb begin
        lead_idx = '0;
        for (int i = VSIZE - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lead_idx = IW'(i);
            end
        end
    end

    assign lead_address = address[lead_idx];

    always_comb begin
        match = '0;
        for (int i = 0; i < VSIZE; i++) begin
            match[i] = pending[i] && (address[i] == lead_address);
        end
    end
endmodule

// File: rtl/accum_warp_addr_drain.sv
// Accepts one warp beat, issues one memory request per unique lane address, pulses retire when drained.
// First request 1 cycle after accept; retire 1 cycle after last request ack (queued behind an earlier retire).
// Beat input stalls while requests are pending, except in the cycle the last request is acked.
module accum_warp_addr_drain
    import accum_warp_addr_drain_pkg::*;
#(
    parameter int N_CFG = N_ICFG,
    parameter int ABW   = GLOBAL_ADDR_BW,
    parameter int VSIZE = accum_warp_addr_drain_pkg::VSIZE,
    localparam int IDW  = $clog2(N_CFG + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      addrval_rdy,
    output logic                      addrval_ack,
    input  logic [IDW-1:0]            i_id,
    input  logic [VSIZE-1:0][ABW-1:0] i_address,
    input  logic [VSIZE-1:0]          i_valid,
    input  logic                      i_retire,
    output logic                      mreq_rdy,
    input  logic                      mreq_ack,
    output logic [IDW-1:0]            o_mreq_id,
    output logic [ABW-1:0]            o_mreq_address,
    output logic [VSIZE-1:0]          o_mreq_lanes,
    output logic                      retire_dval,
    output logic [IDW-1:0]            o_retire_id
);
    drain_state_e              state_q, state_d;
    logic [IDW-1:0]            id_q, id_d;
    logic [VSIZE-1:0][ABW-1:0] addr_q, addr_d;
    logic                      retire_q, retire_d;
    logic [VSIZE-1:0]          pending_q, pending_d;
    logic                      ret_vld_q, ret_vld_d;
    logic [IDW-1:0]            ret_id_q, ret_id_d;
    logic                      spill_vld_q, spill_vld_d;
    logic [IDW-1:0]            spill_id_q, spill_id_d;

    logic [ABW-1:0]   lead_address;
    logic [VSIZE-1:0] match;
    logic [VSIZE-1:0] remaining;
    logic             drain_done;
    logic             can_take;
    logic             ev_drain;
    logic             ev_empty;

    warp_lane_coalescer #(
        .VSIZE (VSIZE),
        .ABW   (ABW)
    ) u_coalescer (
        .address      (addr_q),
        .pending      (pending_q),
        .lead_address (lead_address),
        .match        (match)
    );

    assign remaining   = pending_q & ~match;
    assign drain_done  = (state_q == DRAIN) && mreq_ack && (remaining == '0);
    assign can_take    = (state_q == IDLE) || drain_done;
    assign addrval_ack = i_rst && addrval_rdy && can_take;

    assign mreq_rdy       = (state_q == DRAIN);
    assign o_mreq_id      = mreq_rdy ? id_q : '0;
    assign o_mreq_address = mreq_rdy ? lead_address : '0;
    assign o_mreq_lanes   = mreq_rdy ? match : '0;
    assign retire_dval    = ret_vld_q;
    assign o_retire_id    = ret_id_q;

    assign ev_drain = drain_done && retire_q;
    assign ev_empty = addrval_ack && (i_valid == '0) && i_retire;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        retire_d    = retire_q;
        pending_d   = pending_q;
        ret_vld_d   = 1'b0;
        ret_id_d    = '0;
        spill_vld_d = 1'b0;
        spill_id_d  = '0;

        if ((state_q == DRAIN) && mreq_ack) begin
            pending_d = remaining;
        end
        if (drain_done) begin
            state_d = IDLE;
        end
        if (addrval_ack) begin
            id_d      = i_id;
            addr_d    = i_address;
            retire_d  = i_retire;
            pending_d = i_valid;
            state_d   = (i_valid != '0) ? DRAIN : IDLE;
        end

        // A drained retire beat and an empty retire beat can land in one cycle;
        // the older one goes out first and the newer waits one cycle in the spill slot.
        if (spill_vld_q) begin
            ret_vld_d = 1'b1;
            ret_id_d  = spill_id_q;
            if (ev_drain) begin
                spill_vld_d = 1'b1;
                spill_id_d  = id_q;
            end else if (ev_empty) begin
                spill_vld_d = 1'b1;
                spill_id_d  = i_id;
            end
        end else if (ev_drain) begin
            ret_vld_d = 1'b1;
            ret_id_d  = id_q;
            if (ev_empty) begin
                spill_vld_d = 1'b1;
                spill_id_d  = i_id;
            end
        end else if (ev_empty) begin
            ret_vld_d = 1'b1;
            ret_id_d  = i_id;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            retire_q    <= 1'b0;
            pending_q   <= '0;
            ret_vld_q   <= 1'b0;
            ret_id_q    <= '0;
            spill_vld_q <= 1'b0;
            spill_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            retire_q    <= retire_d;
            pending_q   <= pending_d;
            ret_vld_q   <= ret_vld_d;
            ret_id_q    <= ret_id_d;
            spill_vld_q <= spill_vld_d;
            spill_id_q  <= spill_id_d;
        end
    end
endmodule

// File: tb/tb_accum_warp_addr_drain.sv
// Bench for accum_warp_addr_drain: transaction-level model checked every cycle plus directed literals.
module tb_accum_warp_addr_drain;
    localparam int V  = 4;
    localparam int AW = 16;
    localparam int IW = 3;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [V-1:0]  lanes;
    } req_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              addrval_rdy = 1'b0;
    logic              addrval_ack;
    logic [IW-1:0]     id_in = '0;
    logic [V-1:0][AW-1:0] addr_in = '0;
    logic [V-1:0]      valid_in = '0;
    logic              retire_in = 1'b0;
    logic              mreq_rdy;
    logic              mreq_ack;
    logic              ack_en = 1'b0;
    logic [IW-1:0]     mreq_id;
    logic [AW-1:0]     mreq_addr;
    logic [V-1:0]      mreq_lanes;
    logic              retire_dval;
    logic [IW-1:0]     retire_id;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    assign mreq_ack = ack_en && mreq_rdy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    accum_warp_addr_drain #(.N_CFG(4), .ABW(AW), .VSIZE(V)) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .addrval_rdy    (addrval_rdy),
        .addrval_ack    (addrval_ack),
        .i_id           (id_in),
        .i_address      (addr_in),
        .i_valid        (valid_in),
        .i_retire       (retire_in),
        .mreq_rdy       (mreq_rdy),
        .mreq_ack       (mreq_ack),
        .o_mreq_id      (mreq_id),
        .o_mreq_address (mreq_addr),
        .o_mreq_lanes   (mreq_lanes),
        .retire_dval    (retire_dval),
        .o_retire_id    (retire_id)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model state: outstanding requests of the held beat, and retire ids still owed.
    req_t          cur_q[$];
    logic          cur_ret = 1'b0;
    logic [IW-1:0] cur_id = '0;
    logic [IW-1:0] ret_q[$];

    logic [AW-1:0] log_addr[$];
    logic [V-1:0]  log_lanes[$];
    int            log_cyc[$];
    logic [IW-1:0] log_ret[$];
    int            log_ret_cyc[$];
    int            acc_cyc[$];

    always @(negedge clk) begin : model
        bit   ea;
        bit   dup;
        req_t r;
        if (!rst_n) begin
            chk("rst_addrval_ack", addrval_ack, 0);
            chk("rst_mreq_rdy", mreq_rdy, 0);
            chk("rst_mreq_addr", mreq_addr, 0);
            chk("rst_mreq_lanes", mreq_lanes, 0);
            chk("rst_retire_dval", retire_dval, 0);
            chk("rst_retire_id", retire_id, 0);
            cur_q.delete();
            ret_q.delete();
            cur_ret = 1'b0;
        end else begin
            if (ret_q.size() != 0) begin
                chk("retire_dval", retire_dval, 1);
                chk("retire_id", retire_id, ret_q[0]);
                void'(ret_q.pop_front());
            end else begin
                chk("retire_dval_idle", retire_dval, 0);
            end
            if (retire_dval) begin
                log_ret.push_back(retire_id);
                log_ret_cyc.push_back(cyc);
            end
            chk("mreq_rdy", mreq_rdy, cur_q.size() != 0);
            if (cur_q.size() != 0) begin
                chk("mreq_id", mreq_id, cur_q[0].id);
                chk("mreq_addr", mreq_addr, cur_q[0].addr);
                chk("mreq_lanes", mreq_lanes, cur_q[0].lanes);
            end
            ea = addrval_rdy && (cur_q.size() == 0 || (cur_q.size() == 1 && mreq_ack));
            chk("addrval_ack", addrval_ack, ea);
            if (mreq_ack && cur_q.size() != 0) begin
                log_addr.push_back(mreq_addr);
                log_lanes.push_back(mreq_lanes);
                log_cyc.push_back(cyc);
                void'(cur_q.pop_front());
                if (cur_q.size() == 0 && cur_ret) ret_q.push_back(cur_id);
            end
            if (ea) begin
                acc_cyc.push_back(cyc);
                for (int i = 0; i < V; i++) begin
                    if (valid_in[i]) begin
                        dup = 1'b0;
                        for (int j = 0; j < i; j++)
                            if (valid_in[j] && addr_in[j] == addr_in[i]) dup = 1'b1;
                        if (!dup) begin
                            r.id    = id_in;
                            r.addr  = addr_in[i];
                            r.lanes = '0;
                            for (int k = 0; k < V; k++)
                                if (valid_in[k] && addr_in[k] == addr_in[i]) r.lanes[k] = 1'b1;
                            cur_q.push_back(r);
                        end
                    end
                end
                cur_id  = id_in;
                cur_ret = retire_in;
                if (valid_in == '0 && retire_in) ret_q.push_back(id_in);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting cycle.
    task automatic send(input logic [IW-1:0] id, input logic [V-1:0] vm,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                        input logic ret, output int waited);
        int n = 0;
        id_in = id; valid_in = vm; retire_in = ret;
        addr_in[0] = a0; addr_in[1] = a1; addr_in[2] = a2; addr_in[3] = a3;
        addrval_rdy = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!addrval_ack && n < 200);
        chk("accept_within_bound", addrval_ack, 1);
        waited = n;
        @(posedge clk); #1;
        addrval_rdy = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((cur_q.size() != 0 || ret_q.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_within_bound", n < 500, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int base, rb, w, acc_a, acc_b, nret_exp;
    bit rnd_done;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        addrval_rdy = 1'b1;
        #1;
        chk("lit_rst_ack_gated", addrval_ack, 0);
        chk("lit_rst_mreq_rdy", mreq_rdy, 0);
        addrval_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_en = 1'b1;
        @(posedge clk); #1;

        // Four distinct addresses, retire
        base = log_addr.size(); rb = log_ret.size();
        send(3'd1, 4'b1111, 16'h10, 16'h20, 16'h30, 16'h40, 1'b1, w);
        acc_a = acc_cyc[acc_cyc.size() - 1];
        wait_drain();
        chk("t1_nreq", log_addr.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", log_addr[base + i], 32'((i + 1) * 16));
            chk("t1_lanes", log_lanes[base + i], 32'(1 << i));
        end
        chk("t1_first_lat", log_cyc[base] - acc_a, 1);
        chk("t1_span", log_cyc[base + 3] - log_cyc[base], 3);
        chk("t1_nret", log_ret.size() - rb, 1);
        chk("t1_ret_id", log_ret[rb], 1);
        chk("t1_ret_lat", log_ret_cyc[rb] - log_cyc[base + 3], 1);

        // Coalesced lanes, invalid lane 2 shares no issue
        base = log_addr.size(); rb = log_ret.size();
        send(3'd2, 4'b1011, 16'h50, 16'h50, 16'h99, 16'h50, 1'b0, w);
        wait_drain();
        chk("t2_nreq", log_addr.size() - base, 1);
        chk("t2_addr", log_addr[base], 32'h50);
        chk("t2_lanes", log_lanes[base], 32'b1011);
        chk("t2_nret", log_ret.size() - rb, 0);

        // Empty mask with retire
        base = log_addr.size(); rb = log_ret.size();
        send(3'd3, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, w);
        acc_a = acc_cyc[acc_cyc.size() - 1];
        wait_drain();
        chk("t3_no_stall", w, 1);
        chk("t3_nreq", log_addr.size() - base, 0);
        chk("t3_ret_id", log_ret[rb], 3);
        chk("t3_ret_lat", log_ret_cyc[rb] - acc_a, 1);

        // Back-to-back beats with a 5-cycle request stall
        base = log_addr.size(); rb = log_ret.size();
        ack_en = 1'b0;
        send(3'd1, 4'b0011, 16'h100, 16'h200, 16'h0, 16'h0, 1'b1, w);
        acc_a = acc_cyc[acc_cyc.size() - 1];
        fork
            send(3'd2, 4'b0001, 16'h300, 16'h0, 16'h0, 16'h0, 1'b0, w);
            begin
                repeat (5) @(posedge clk);
                #1 ack_en = 1'b1;
            end
        join
        acc_b = acc_cyc[acc_cyc.size() - 1];
        wait_drain();
        chk("t4_nreq", log_addr.size() - base, 3);
        chk("t4_stall", log_cyc[base] - acc_a, 6);
        chk("t4_b_accept_on_last_ack", acc_b - log_cyc[base + 1], 0);
        chk("t4_b_first_req", log_cyc[base + 2] - acc_b, 1);
        chk("t4_b_addr", log_addr[base + 2], 32'h300);
        chk("t4_ret_id", log_ret[rb], 1);

        // Reset with two lanes pending
        rb = log_ret.size();
        ack_en = 1'b0;
        send(3'd2, 4'b0011, 16'h10, 16'h20, 16'h0, 16'h0, 1'b1, w);
        @(posedge clk); #1;
        addrval_rdy = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_mreq_rdy", mreq_rdy, 0);
        chk("t5_rst_lanes", mreq_lanes, 0);
        chk("t5_rst_addr", mreq_addr, 0);
        chk("t5_rst_ack", addrval_ack, 0);
        addrval_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_ret_after_rst", log_ret.size() - rb, 0);
        base = log_addr.size();
        send(3'd5, 4'b0001, 16'h77, 16'h0, 16'h0, 16'h0, 1'b1, w);
        wait_drain();
        chk("t5_addr", log_addr[base], 32'h77);
        chk("t5_ret_id", log_ret[rb], 5);

        // Drained retire and empty retire beat in the same cycle
        rb = log_ret.size();
        send(3'd1, 4'b0001, 16'h5, 16'h0, 16'h0, 16'h0, 1'b1, w);
        send(3'd2, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, w);
        wait_drain();
        chk("t6_nret", log_ret.size() - rb, 2);
        chk("t6_ret0", log_ret[rb], 1);
        chk("t6_ret1", log_ret[rb + 1], 2);
        chk("t6_ret_gap", log_ret_cyc[rb + 1] - log_ret_cyc[rb], 1);

        // Random beats with random request backpressure
        rb = log_ret.size();
        nret_exp = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 60; b++) begin
                    logic [V-1:0] vm;
                    logic         rt;
                    vm = V'($urandom_range(0, 15));
                    rt = 1'($urandom_range(0, 1));
                    if (rt) nret_exp++;
                    send(IW'($urandom_range(1, 4)), vm,
                         AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                         AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), rt, w);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    ack_en = 1'($urandom_range(0, 1));
                end
                ack_en = 1'b1;
            end
        join
        wait_drain();
        chk("rnd_nret", log_ret.size() - rb, nret_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
